// File: rtl/vga_axi_rd_arb.sv
// Two-master AXI4 read arbiter: VGA fetcher (m0) has priority,
// m1 is guaranteed service by a starvation counter.
module vga_axi_rd_arb #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_a,
  input  logic                  resetn_a,
  input  logic [ADDR_WIDTH-1:0] m0_araddr_i,
  input  logic [1:0]            m0_arburst_i,
  input  logic [7:0]            m0_arlen_i,
  input  logic [2:0]            m0_arsize_i,
  input  logic                  m0_arvalid_i,
  output logic                  m0_arready_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic [1:0]            m0_rresp_o,
  output logic                  m0_rlast_o,
  input  logic                  m0_rready_i,
  input  logic [ADDR_WIDTH-1:0] m1_araddr_i,
  input  logic [1:0]            m1_arburst_i,
  input  logic [7:0]            m1_arlen_i,
  input  logic [2:0]            m1_arsize_i,
  input  logic                  m1_arvalid_i,
  output logic                  m1_arready_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic [1:0]            m1_rresp_o,
  output logic                  m1_rlast_o,
  input  logic                  m1_rready_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [1:0]            arburst_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic                  rvalid_i,
  input  logic [1:0]            rresp_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  rready_o,
  output logic                  grant_o,
  output logic                  busy_o,
  output logic [15:0]           err_cnt_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state;
  logic [7:0] len;
  logic [7:0] beat_cnt;
  logic [7:0] starve_cnt;

  logic req;
  logic pick1;
  logic arb;
  logic in_data;
  logic sel0;
  logic sel1;
  logic last;
  logic beat;

  assign req   = m0_arvalid_i | m1_arvalid_i;
  assign pick1 = m1_arvalid_i &
                 (~m0_arvalid_i |
                  (starve_cnt == 8'(STARVE_LIMIT)));

  // arready is combinational, so hold it low while reset is asserted
  assign arb          = resetn_a & (state == IDLE) & req;
  assign m0_arready_o = arb & ~pick1;
  assign m1_arready_o = arb & pick1;

  assign in_data  = (state == DATA);
  assign sel0     = in_data & ~grant_o;
  assign sel1     = in_data & grant_o;
  assign last     = (beat_cnt == len);
  assign rready_o = (sel0 & m0_rready_i) |
                    (sel1 & m1_rready_i);
  assign beat     = rvalid_i & rready_o;

  assign m0_rvalid_o = sel0 & rvalid_i;
  assign m0_rdata_o  = sel0 ? rdata_i : '0;
  assign m0_rresp_o  = sel0 ? rresp_i : '0;
  assign m0_rlast_o  = sel0 & last;

  assign m1_rvalid_o = sel1 & rvalid_i;
  assign m1_rdata_o  = sel1 ? rdata_i : '0;
  assign m1_rresp_o  = sel1 ? rresp_i : '0;
  assign m1_rlast_o  = sel1 & last;

  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      state      <= IDLE;
      araddr_o   <= '0;
      arburst_o  <= '0;
      arlen_o    <= '0;
      arsize_o   <= '0;
      arvalid_o  <= 1'b0;
      grant_o    <= 1'b0;
      busy_o     <= 1'b0;
      len        <= '0;
      beat_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= ADDR;
            busy_o    <= 1'b1;
            arvalid_o <= 1'b1;
            grant_o   <= pick1;
            araddr_o  <= pick1 ? m1_araddr_i : m0_araddr_i;
            arburst_o <= pick1 ? m1_arburst_i : m0_arburst_i;
            arlen_o   <= pick1 ? m1_arlen_i : m0_arlen_i;
            arsize_o  <= pick1 ? m1_arsize_i : m0_arsize_i;
            len       <= pick1 ? m1_arlen_i : m0_arlen_i;
            if (pick1) begin
              starve_cnt <= '0;
            end else if (m1_arvalid_i &&
                         starve_cnt != 8'(STARVE_LIMIT)) begin
              starve_cnt <= starve_cnt + 8'd1;
            end
          end
        end
        ADDR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy_o    <= 1'b0;
          arvalid_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      err_cnt_o <= '0;
    end else if (beat && rresp_i[1] &&
                 err_cnt_o != 16'hFFFF) begin
      err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_axi_rd_arb.sv
// Randomized scoreboard bench for vga_axi_rd_arb with a
// transaction-level model of arbitration, bursts and error count.
module tb_vga_axi_rd_arb;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SL = 4;

  logic          clk_a = 1'b0;
  logic          resetn_a;
  logic [AW-1:0] m0_araddr_i, m1_araddr_i;
  logic [1:0]    m0_arburst_i, m1_arburst_i;
  logic [7:0]    m0_arlen_i, m1_arlen_i;
  logic [2:0]    m0_arsize_i, m1_arsize_i;
  logic          m0_arvalid_i, m1_arvalid_i;
  logic          m0_arready_o, m1_arready_o;
  logic          m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic [1:0]    m0_rresp_o, m1_rresp_o;
  logic          m0_rlast_o, m1_rlast_o;
  logic          m0_rready_i, m1_rready_i;
  logic [AW-1:0] araddr_o;
  logic [1:0]    arburst_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic          arvalid_o, arready_i, rvalid_i;
  logic [1:0]    rresp_i;
  logic [DW-1:0] rdata_i;
  logic          rready_o, grant_o, busy_o;
  logic [15:0]   err_cnt_o;

  always #5 clk_a = ~clk_a;

  vga_axi_rd_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)
  ) dut (
    .clk_a(clk_a), .resetn_a(resetn_a),
    .m0_araddr_i(m0_araddr_i), .m0_arburst_i(m0_arburst_i),
    .m0_arlen_i(m0_arlen_i), .m0_arsize_i(m0_arsize_i),
    .m0_arvalid_i(m0_arvalid_i), .m0_arready_o(m0_arready_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m0_rresp_o(m0_rresp_o), .m0_rlast_o(m0_rlast_o),
    .m0_rready_i(m0_rready_i),
    .m1_araddr_i(m1_araddr_i), .m1_arburst_i(m1_arburst_i),
    .m1_arlen_i(m1_arlen_i), .m1_arsize_i(m1_arsize_i),
    .m1_arvalid_i(m1_arvalid_i), .m1_arready_o(m1_arready_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .m1_rresp_o(m1_rresp_o), .m1_rlast_o(m1_rlast_o),
    .m1_rready_i(m1_rready_i),
    .araddr_o(araddr_o), .arburst_o(arburst_o),
    .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rresp_i(rresp_i), .rdata_i(rdata_i),
    .rready_o(rready_o), .grant_o(grant_o), .busy_o(busy_o),
    .err_cnt_o(err_cnt_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // requester and slave stimulus state
  int            left [2];
  bit            always_req;
  int            force_len;
  logic [AW-1:0] q_addr [2];
  logic [1:0]    q_burst [2];
  logic [7:0]    q_len [2];
  logic [2:0]    q_size [2];
  bit            q_val [2];
  bit            q_rdy [2];
  int            beats_left;

  // reference model
  typedef struct packed {
    logic          own;
    logic [AW-1:0] addr;
    logic [1:0]    burst;
    logic [7:0]    len;
    logic [2:0]    size;
  } txn_t;

  txn_t       ar_q [$];
  int         grant_log [$];
  int         streak;
  bit         addr_ph, data_ph, open, own;
  logic [7:0] cur_len;
  int         idx, exp_err;
  bit         mon_en;
  bit         arb_hs [2];
  bit         ar_hs_f, beat_hs_f;
  int         slave_len;

  task automatic drive_ports();
    m0_arvalid_i = q_val[0];
    m0_araddr_i  = q_addr[0];
    m0_arburst_i = q_burst[0];
    m0_arlen_i   = q_len[0];
    m0_arsize_i  = q_size[0];
    m0_rready_i  = q_rdy[0];
    m1_arvalid_i = q_val[1];
    m1_araddr_i  = q_addr[1];
    m1_arburst_i = q_burst[1];
    m1_arlen_i   = q_len[1];
    m1_arsize_i  = q_size[1];
    m1_rready_i  = q_rdy[1];
  endtask

  task automatic model_reset();
    ar_q.delete();
    streak    = 0;
    addr_ph   = 0;
    data_ph   = 0;
    open      = 0;
    own       = 0;
    cur_len   = '0;
    idx       = 0;
    exp_err   = 0;
    arb_hs    = '{0, 0};
    ar_hs_f   = 0;
    beat_hs_f = 0;
    slave_len = 0;
    beats_left = 0;
    left      = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      q_val[k]   = 0;
      q_rdy[k]   = 0;
      q_addr[k]  = '0;
      q_burst[k] = '0;
      q_len[k]   = '0;
      q_size[k]  = '0;
    end
    drive_ports();
    arready_i = 0;
    rvalid_i  = 0;
    rresp_i   = '0;
    rdata_i   = '0;
  endtask

  task automatic step();
    for (int k = 0; k < 2; k++) begin
      if (arb_hs[k]) begin
        q_val[k]  = 0;
        arb_hs[k] = 0;
      end
      if (!q_val[k] && left[k] > 0 &&
          (always_req || $urandom_range(0, 3) == 0)) begin
        q_val[k]   = 1;
        q_addr[k]  = {$urandom, $urandom};
        q_burst[k] = 2'($urandom_range(0, 2));
        q_len[k]   = (force_len >= 0) ? 8'(force_len)
                                      : 8'($urandom_range(0, 7));
        q_size[k]  = 3'($urandom_range(0, 6));
        left[k]--;
      end
      q_rdy[k] = always_req || ($urandom_range(0, 3) != 0);
    end
    drive_ports();
    arready_i = ($urandom_range(0, 2) != 0);
    if (ar_hs_f) begin
      ar_hs_f    = 0;
      beats_left = slave_len + 1;
      rvalid_i   = 0;
    end
    if (beat_hs_f) begin
      beat_hs_f = 0;
      beats_left--;
      rvalid_i  = 0;
    end
    if (beats_left > 0) begin
      if (!rvalid_i && $urandom_range(0, 3) != 0) begin
        rvalid_i = 1;
        rdata_i  = {$urandom, $urandom};
        rresp_i  = 2'($urandom_range(0, 3));
      end
    end else begin
      // stray slave traffic outside a burst must be ignored
      rvalid_i = ($urandom_range(0, 4) == 0);
      rdata_i  = {$urandom, $urandom};
      rresp_i  = 2'($urandom_range(0, 3));
    end
  endtask

  function automatic bit idle_all();
    return left[0] == 0 && left[1] == 0 &&
           !q_val[0] && !q_val[1] && !open;
  endfunction

  task automatic run_phase(input int budget, input string name);
    int n;
    n = 0;
    while (!idle_all() && n < budget) begin
      @(posedge clk_a);
      #1;
      step();
      n++;
    end
    checks++;
    if (!idle_all()) begin
      failures++;
      $display("FAIL %s timeout actual=busy required=idle", name);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ar"},
        {araddr_o, arburst_o, arlen_o, arsize_o, arvalid_o}, '0);
    chk({tag, "_m0"},
        {m0_arready_o, m0_rvalid_o, m0_rdata_o,
         m0_rresp_o, m0_rlast_o}, '0);
    chk({tag, "_m1"},
        {m1_arready_o, m1_rvalid_o, m1_rdata_o,
         m1_rresp_o, m1_rlast_o}, '0);
    chk({tag, "_misc"},
        {rready_o, grant_o, busy_o, err_cnt_o}, '0);
  endtask

  task automatic chk_seq(input string name);
    int exp_seq [10];
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      if (i < grant_log.size()) begin
        chk(name, grant_log[i], exp_seq[i]);
      end else begin
        checks++;
        failures++;
        $display("FAIL %s grant %0d actual=none required=%0d",
                 name, i, exp_seq[i]);
      end
    end
  endtask

  always @(negedge clk_a) begin : mon
    bit          was_open, exp1, exp_rr;
    txn_t        t;
    logic [68:0] o0, o1, live;
    if (mon_en) begin
      was_open = open;
      chk("busy", busy_o, open);
      chk("arvalid", arvalid_o, addr_ph);
      chk("err_cnt", err_cnt_o, exp_err);
      if (open) chk("grant", grant_o, own);
      if (addr_ph && ar_q.size() > 0) begin
        t = ar_q[0];
        chk("ar_fields",
            {araddr_o, arburst_o, arlen_o, arsize_o},
            {t.addr, t.burst, t.len, t.size});
      end
      o0 = {m0_rvalid_o, m0_rdata_o, m0_rresp_o, m0_rlast_o};
      o1 = {m1_rvalid_o, m1_rdata_o, m1_rresp_o, m1_rlast_o};
      exp_rr = 0;
      if (data_ph) begin
        exp_rr = own ? m1_rready_i : m0_rready_i;
        live = {rvalid_i, rdata_i, rresp_i, (idx == int'(cur_len))};
        chk("r_owner", own ? o1 : o0, live);
        chk("r_other", own ? o0 : o1, '0);
      end else begin
        chk("r_idle", {o0, o1}, '0);
      end
      chk("rready", rready_o, exp_rr);
      if (data_ph && rvalid_i && exp_rr) begin
        if (rresp_i[1] && exp_err < 65535) exp_err++;
        beat_hs_f = 1;
        if (idx == int'(cur_len)) begin
          data_ph = 0;
          open    = 0;
        end else begin
          idx++;
        end
      end
      if (addr_ph && arready_i && ar_q.size() > 0) begin
        t         = ar_q.pop_front();
        addr_ph   = 0;
        data_ph   = 1;
        cur_len   = t.len;
        idx       = 0;
        ar_hs_f   = 1;
        slave_len = int'(t.len);
      end
      if (!was_open && (m0_arvalid_i || m1_arvalid_i)) begin
        exp1 = m1_arvalid_i && (!m0_arvalid_i || streak >= SL);
        chk("arb_winner", {m1_arready_o, m0_arready_o},
            exp1 ? 2'b10 : 2'b01);
        grant_log.push_back(int'(m1_arready_o));
        t.own   = exp1;
        t.addr  = exp1 ? m1_araddr_i : m0_araddr_i;
        t.burst = exp1 ? m1_arburst_i : m0_arburst_i;
        t.len   = exp1 ? m1_arlen_i : m0_arlen_i;
        t.size  = exp1 ? m1_arsize_i : m0_arsize_i;
        ar_q.push_back(t);
        if (exp1) streak = 0;
        else if (m1_arvalid_i) streak++;
        own          = exp1;
        open         = 1;
        addr_ph      = 1;
        arb_hs[exp1] = 1;
      end else begin
        chk("arready_quiet", {m1_arready_o, m0_arready_o}, 2'b00);
      end
    end
  end

  initial begin
    int n;
    mon_en     = 0;
    always_req = 0;
    force_len  = -1;
    resetn_a   = 1;
    model_reset();
    #1;
    resetn_a = 0;
    #2;
    chk_zero("reset");
    #19;
    resetn_a = 1;
    mon_en   = 1;

    grant_log.delete();
    always_req = 1;
    left       = '{10, 3};
    run_phase(2000, "starve_phase");
    chk_seq("grant_seq");

    always_req = 0;
    left       = '{20, 20};
    run_phase(5000, "random_a");

    force_len  = 3;
    always_req = 1;
    left       = '{1, 0};
    n = 0;
    while (!(data_ph && idx == 2) && n < 500) begin
      @(posedge clk_a);
      #1;
      step();
      n++;
    end
    checks++;
    if (!(data_ph && idx == 2)) begin
      failures++;
      $display("FAIL mid_burst actual=not_reached required=beat2");
    end
    #2;
    mon_en   = 0;
    resetn_a = 0;
    #1;
    chk_zero("mid_reset");
    model_reset();
    force_len  = -1;
    always_req = 0;
    @(negedge clk_a);
    #1;
    resetn_a = 1;
    mon_en   = 1;

    grant_log.delete();
    always_req = 1;
    left       = '{10, 3};
    run_phase(2000, "starve_after_reset");
    chk_seq("grant_seq_rst");

    always_req = 0;
    left       = '{20, 20};
    run_phase(5000, "random_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
